// File: rtl/rv_pkg.sv
// Shared execute-stage types: ALU control encoding, branch-resolve FSM states
// and the sequential PC step.
package rv_pkg;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_SLL  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_EQ   = 4'd8,
      ALU_NE   = 4'd9,
      ALU_SLT  = 4'd10,
      ALU_GE   = 4'd11,
      ALU_SLTU = 4'd12,
      ALU_GEU  = 4'd13
   } alu_ctrl_e;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      EVAL     = 2'd1,
      REDIRECT = 2'd2,
      FLUSH    = 2'd3
   } br_ctrl_state_e;

   localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/branch_cmp.sv
// Combinational branch comparator: evaluates the branch condition for the
// compare ops; every other ALU op yields a false condition.
module branch_cmp
   import rv_pkg::*;
(
   input  logic [31:0] rs1,
   input  logic [31:0] rs2,
   input  alu_ctrl_e   op,
   output logic        cond
);

   always_comb begin
      cond = 1'b0;
      case (op)
         ALU_EQ:   cond = (rs1 == rs2);
         ALU_NE:   cond = (rs1 != rs2);
         ALU_SLT:  cond = ($signed(rs1) <  $signed(rs2));
         ALU_GE:   cond = ($signed(rs1) >= $signed(rs2));
         ALU_SLTU: cond = (rs1 <  rs2);
         ALU_GEU:  cond = (rs1 >= rs2);
         default:  cond = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Execute-stage branch/jump resolution: evaluates one control transfer at a
// time, redirects fetch on mispredict and holds a multi-cycle flush.
module branch_resolve_ctrl
   import rv_pkg::*;
#(
   parameter int unsigned FLUSH_CYCLES = 2,
   parameter int unsigned CNT_W        = 32
)
(
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_br_valid,
   output logic             o_br_ready,
   input  logic [31:0]      i_br_pc,
   input  logic [31:0]      i_rs1,
   input  logic [31:0]      i_rs2,
   input  logic [31:0]      i_imm,
   input  alu_ctrl_e        i_br_op,
   input  logic             i_is_jal,
   input  logic             i_is_jalr,
   input  logic             i_pred_taken,
   output logic             o_link_valid,
   output logic [31:0]      o_link_pc,
   output logic             o_redirect,
   output logic [31:0]      o_redirect_pc,
   output logic             o_flush,
   output logic             o_misalign,
   output logic [CNT_W-1:0] o_br_count,
   output logic [CNT_W-1:0] o_mispred_count
);

   localparam int unsigned     FC_W    = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES - 1) : 1;
   localparam logic [FC_W-1:0] FC_LOAD = (FLUSH_CYCLES > 1) ? FC_W'(FLUSH_CYCLES - 2) : '0;

   br_ctrl_state_e   state_q, state_d;

   logic [31:0]      req_pc, req_rs1, req_rs2, req_imm;
   alu_ctrl_e        req_op;
   logic             req_jal, req_jalr, req_pred;

   logic [31:0]      redir_pc_q;
   logic [FC_W-1:0]  flush_cnt_q;
   logic [CNT_W-1:0] br_cnt_q, mis_cnt_q;

   logic             cond, taken, is_jump, misalign, mispredict;
   logic [31:0]      target_sum, target, seq_pc, next_pc;

   branch_cmp u_cmp (
      .rs1  (req_rs1),
      .rs2  (req_rs2),
      .op   (req_op),
      .cond (cond)
   );

   // JALR clears bit 0 of its target; bit 1 set on a taken path is a misaligned fetch.
   always_comb begin
      is_jump    = req_jal | req_jalr;
      taken      = is_jump | cond;
      target_sum = req_jalr ? (req_rs1 + req_imm) : (req_pc + req_imm);
      target     = {target_sum[31:1], target_sum[0] & ~req_jalr};
      seq_pc     = req_pc + PC_STEP;
      next_pc    = taken ? target : seq_pc;
      misalign   = taken & target[1];
      mispredict = ~misalign & ((taken != req_pred) | req_jalr);
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:     if (i_br_valid) state_d = EVAL;
         EVAL:     state_d = mispredict ? REDIRECT : IDLE;
         REDIRECT: state_d = (FLUSH_CYCLES == 1) ? IDLE : FLUSH;
         FLUSH:    if (flush_cnt_q == '0) state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q     <= IDLE;
         req_pc      <= '0;
         req_rs1     <= '0;
         req_rs2     <= '0;
         req_imm     <= '0;
         req_op      <= ALU_ADD;
         req_jal     <= 1'b0;
         req_jalr    <= 1'b0;
         req_pred    <= 1'b0;
         redir_pc_q  <= '0;
         flush_cnt_q <= '0;
         br_cnt_q    <= '0;
         mis_cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && i_br_valid) begin
            req_pc   <= i_br_pc;
            req_rs1  <= i_rs1;
            req_rs2  <= i_rs2;
            req_imm  <= i_imm;
            req_op   <= i_br_op;
            req_jal  <= i_is_jal;
            req_jalr <= i_is_jalr;
            req_pred <= i_pred_taken;
         end
         if (state_q == EVAL) begin
            br_cnt_q   <= br_cnt_q + CNT_W'(1);
            redir_pc_q <= next_pc;
         end
         if (state_q == REDIRECT) begin
            mis_cnt_q   <= mis_cnt_q + CNT_W'(1);
            flush_cnt_q <= FC_LOAD;
         end
         if (state_q == FLUSH && flush_cnt_q != '0) begin
            flush_cnt_q <= flush_cnt_q - FC_W'(1);
         end
      end
   end

   always_comb begin
      o_br_ready      = (state_q == IDLE) & ~i_rst;
      o_link_valid    = (state_q == EVAL) & is_jump;
      o_link_pc       = o_link_valid ? seq_pc : '0;
      o_misalign      = (state_q == EVAL) & misalign;
      o_redirect      = (state_q == REDIRECT);
      o_redirect_pc   = o_redirect ? redir_pc_q : '0;
      o_flush         = (state_q == REDIRECT) | (state_q == FLUSH);
      o_br_count      = br_cnt_q;
      o_mispred_count = mis_cnt_q;
   end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Bench for branch_resolve_ctrl: directed vector table, reset and wrap
// sequences, and randomized requests checked against a transaction model.
module tb_branch_resolve_ctrl;
   import rv_pkg::*;

   localparam int unsigned FC = 2;

   typedef struct {
      logic [31:0] pc, rs1, rs2, imm;
      alu_ctrl_e   op;
      logic        jal, jalr, pred;
   } req_t;

   typedef struct {
      logic        link;
      logic [31:0] link_pc;
      logic        mis;
      logic        redir;
      logic [31:0] rpc;
   } exp_t;

   typedef struct {
      req_t r;
      exp_t e;
   } vec_t;

   logic        clk = 1'b0;
   logic        i_rst, i_br_valid, i_is_jal, i_is_jalr, i_pred_taken;
   logic [31:0] i_br_pc, i_rs1, i_rs2, i_imm;
   alu_ctrl_e   i_br_op;
   logic        o_br_ready, o_link_valid, o_redirect, o_flush, o_misalign;
   logic [31:0] o_link_pc, o_redirect_pc, o_br_count, o_mispred_count;

   logic        w_rst, w_valid, w_jal;
   logic [31:0] w_pc, w_imm;
   logic        w_ready, w_link_valid, w_redirect, w_flush, w_misalign;
   logic [31:0] w_link_pc, w_redirect_pc;
   logic [2:0]  w_br_count, w_mispred_count;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;
   logic [31:0] exp_br  = '0;
   logic [31:0] exp_mis = '0;
   vec_t        vecs[$];

   always #5 clk = ~clk;

   branch_resolve_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(32)) dut (
      .i_clk(clk), .i_rst(i_rst), .i_br_valid(i_br_valid), .o_br_ready(o_br_ready),
      .i_br_pc(i_br_pc), .i_rs1(i_rs1), .i_rs2(i_rs2), .i_imm(i_imm),
      .i_br_op(i_br_op), .i_is_jal(i_is_jal), .i_is_jalr(i_is_jalr),
      .i_pred_taken(i_pred_taken), .o_link_valid(o_link_valid), .o_link_pc(o_link_pc),
      .o_redirect(o_redirect), .o_redirect_pc(o_redirect_pc), .o_flush(o_flush),
      .o_misalign(o_misalign), .o_br_count(o_br_count), .o_mispred_count(o_mispred_count)
   );

   branch_resolve_ctrl #(.FLUSH_CYCLES(1), .CNT_W(3)) dut_w (
      .i_clk(clk), .i_rst(w_rst), .i_br_valid(w_valid), .o_br_ready(w_ready),
      .i_br_pc(w_pc), .i_rs1(32'd0), .i_rs2(32'd0), .i_imm(w_imm),
      .i_br_op(ALU_EQ), .i_is_jal(w_jal), .i_is_jalr(1'b0),
      .i_pred_taken(1'b0), .o_link_valid(w_link_valid), .o_link_pc(w_link_pc),
      .o_redirect(w_redirect), .o_redirect_pc(w_redirect_pc), .o_flush(w_flush),
      .o_misalign(w_misalign), .o_br_count(w_br_count), .o_mispred_count(w_mispred_count)
   );

   initial begin
      #500000;
      $display("FAIL global_timeout got running expected finished");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Transaction-level reference: resolves one request from the ISA rules.
   function automatic exp_t model(input req_t r);
      exp_t        e;
      logic        c, tk;
      logic [31:0] tgt;
      case (r.op)
         ALU_EQ:   c = (r.rs1 == r.rs2);
         ALU_NE:   c = (r.rs1 != r.rs2);
         ALU_SLT:  c = (int'(r.rs1) <  int'(r.rs2));
         ALU_GE:   c = (int'(r.rs1) >= int'(r.rs2));
         ALU_SLTU: c = ({32'd0, r.rs1} <  {32'd0, r.rs2});
         ALU_GEU:  c = ({32'd0, r.rs1} >= {32'd0, r.rs2});
         default:  c = 1'b0;
      endcase
      tk        = r.jal | r.jalr | c;
      tgt       = r.jalr ? ((r.rs1 + r.imm) & 32'hFFFF_FFFE) : (r.pc + r.imm);
      e.link    = r.jal | r.jalr;
      e.link_pc = r.pc + 32'd4;
      e.mis     = tk & tgt[1];
      e.redir   = ~e.mis & ((tk != r.pred) | r.jalr);
      e.rpc     = tk ? tgt : r.pc + 32'd4;
      return e;
   endfunction

   task automatic add_vec(input logic [31:0] pc, rs1, rs2, imm, input alu_ctrl_e op,
                          input logic jal, jalr, pred, link, input logic [31:0] lpc,
                          input logic mis, redir, input logic [31:0] rpc);
      vec_t v;
      v.r = '{pc: pc, rs1: rs1, rs2: rs2, imm: imm, op: op, jal: jal, jalr: jalr, pred: pred};
      v.e = '{link: link, link_pc: lpc, mis: mis, redir: redir, rpc: rpc};
      vecs.push_back(v);
   endtask

   task automatic drive_req(input req_t r);
      i_br_pc = r.pc; i_rs1 = r.rs1; i_rs2 = r.rs2; i_imm = r.imm;
      i_br_op = r.op; i_is_jal = r.jal; i_is_jalr = r.jalr; i_pred_taken = r.pred;
   endtask

   task automatic junk();
      i_br_valid = 1'b1;
      i_br_pc = $urandom; i_rs1 = $urandom; i_rs2 = $urandom; i_imm = $urandom;
      i_br_op = alu_ctrl_e'(4'($urandom_range(0, 15)));
      i_is_jal = 1'($urandom); i_is_jalr = 1'b0; i_pred_taken = 1'($urandom);
   endtask

   task automatic run_branch(input req_t r, input exp_t e, input logic hold, input string tag);
      int unsigned n = 0;
      while (!o_br_ready && n < 50) begin tick(); n++; end
      chk({tag, " ready_in"}, o_br_ready, 1);
      drive_req(r);
      i_br_valid = 1'b1;
      tick();
      if (hold) junk(); else i_br_valid = 1'b0;
      chk({tag, " link_valid"}, o_link_valid, e.link);
      if (e.link) chk({tag, " link_pc"}, o_link_pc, e.link_pc);
      chk({tag, " misalign"}, o_misalign, e.mis);
      chk({tag, " eval_redirect"}, o_redirect, 0);
      chk({tag, " eval_flush"}, o_flush, 0);
      chk({tag, " eval_ready"}, o_br_ready, 0);
      exp_br++;
      tick();
      if (hold) junk();
      chk({tag, " br_count"}, o_br_count, exp_br);
      if (e.redir) begin
         chk({tag, " redirect"}, o_redirect, 1);
         chk({tag, " redirect_pc"}, o_redirect_pc, e.rpc);
         chk({tag, " redir_flush"}, o_flush, 1);
         chk({tag, " redir_ready"}, o_br_ready, 0);
         chk({tag, " redir_link"}, o_link_valid, 0);
         exp_mis++;
         for (int k = 1; k < int'(FC); k++) begin
            tick();
            if (hold) junk();
            chk({tag, " hold_flush"}, o_flush, 1);
            chk({tag, " hold_redirect"}, o_redirect, 0);
            chk({tag, " hold_ready"}, o_br_ready, 0);
         end
         tick();
      end
      chk({tag, " done_redirect"}, o_redirect, 0);
      chk({tag, " done_flush"}, o_flush, 0);
      chk({tag, " done_ready"}, o_br_ready, 1);
      chk({tag, " mispred_count"}, o_mispred_count, exp_mis);
      i_br_valid = 1'b0;
   endtask

   task automatic run_jal_w(input logic [31:0] pc, imm, input int unsigned k);
      int unsigned n = 0;
      while (!w_ready && n < 20) begin tick(); n++; end
      chk("w ready_in", w_ready, 1);
      w_pc = pc; w_imm = imm; w_jal = 1'b1; w_valid = 1'b1;
      tick();
      w_valid = 1'b0;
      chk("w link_valid", w_link_valid, 1);
      chk("w link_pc", w_link_pc, pc + 32'd4);
      chk("w misalign", w_misalign, 0);
      tick();
      chk("w redirect", w_redirect, 1);
      chk("w redirect_pc", w_redirect_pc, pc + imm);
      chk("w flush", w_flush, 1);
      tick();
      chk("w flush_one_cycle", w_flush, 0);
      chk("w ready_back", w_ready, 1);
      chk("w br_count", w_br_count, 3'(k));
      chk("w mispred_count", w_mispred_count, 3'(k));
   endtask

   initial begin
      req_t r;
      exp_t e;
      int unsigned kind;

      i_rst = 1'b1; i_br_valid = 1'b0;
      drive_req('{pc: '0, rs1: '0, rs2: '0, imm: '0, op: ALU_ADD, jal: 0, jalr: 0, pred: 0});
      w_rst = 1'b1; w_valid = 1'b0; w_jal = 1'b0; w_pc = '0; w_imm = '0;

      //       pc            rs1           rs2           imm           op        jal jalr pred link lpc           mis redir rpc
      add_vec(32'h100,      32'd5,        32'd5,        32'h20,       ALU_EQ,   0, 0, 0, 0, 32'h0,        0, 1, 32'h120);
      add_vec(32'h200,      32'hFFFFFFFF, 32'd1,        32'h40,       ALU_SLT,  0, 0, 1, 0, 32'h0,        0, 0, 32'h0);
      add_vec(32'h300,      32'hFFFFFFFF, 32'd1,        32'h80,       ALU_GEU,  0, 0, 0, 0, 32'h0,        0, 1, 32'h380);
      add_vec(32'h384,      32'd3,        32'd3,        32'h40,       ALU_NE,   0, 0, 0, 0, 32'h0,        0, 0, 32'h0);
      add_vec(32'h400,      32'h203,      32'd0,        32'h10,       ALU_ADD,  0, 1, 0, 1, 32'h404,      1, 0, 32'h0);
      add_vec(32'h400,      32'h201,      32'd0,        32'h10,       ALU_ADD,  0, 1, 1, 1, 32'h404,      0, 1, 32'h210);
      add_vec(32'h500,      32'd0,        32'd0,        32'hFFFFFFF0, ALU_ADD,  1, 0, 1, 1, 32'h504,      0, 0, 32'h0);
      add_vec(32'h600,      32'd0,        32'd0,        32'h8,        ALU_ADD,  1, 0, 0, 1, 32'h604,      0, 1, 32'h608);
      add_vec(32'h700,      32'd9,        32'd9,        32'h30,       ALU_NE,   0, 0, 1, 0, 32'h0,        0, 1, 32'h704);
      add_vec(32'h800,      32'd7,        32'd7,        32'h30,       ALU_ADD,  0, 0, 1, 0, 32'h0,        0, 1, 32'h804);
      add_vec(32'h900,      32'h80000000, 32'd0,        32'h30,       ALU_GE,   0, 0, 0, 0, 32'h0,        0, 0, 32'h0);
      add_vec(32'hA00,      32'd1,        32'hFFFFFFFF, 32'h6,        ALU_SLTU, 0, 0, 0, 0, 32'h0,        1, 0, 32'h0);
      add_vec(32'hFFFFFFF0, 32'd4,        32'd4,        32'h20,       ALU_EQ,   0, 0, 0, 0, 32'h0,        0, 1, 32'h10);

      tick(); tick();
      chk("rst ready", o_br_ready, 0);
      chk("rst link_valid", o_link_valid, 0);
      chk("rst redirect", o_redirect, 0);
      chk("rst redirect_pc", o_redirect_pc, 0);
      chk("rst flush", o_flush, 0);
      chk("rst misalign", o_misalign, 0);
      chk("rst br_count", o_br_count, 0);
      chk("rst mispred_count", o_mispred_count, 0);
      i_rst = 1'b0; w_rst = 1'b0;
      #1;
      chk("rst_release ready", o_br_ready, 1);

      foreach (vecs[i]) run_branch(vecs[i].r, vecs[i].e, 1'b0, $sformatf("vec%0d", i));

      // Reset while a redirect is in flight drops the branch.
      r = '{pc: 32'h100, rs1: 32'd5, rs2: 32'd5, imm: 32'h20, op: ALU_EQ, jal: 0, jalr: 0, pred: 0};
      drive_req(r);
      i_br_valid = 1'b1;
      tick();
      i_br_valid = 1'b0;
      tick();
      chk("rstmid in_redirect", o_redirect, 1);
      i_rst = 1'b1;
      tick();
      chk("rstmid redirect", o_redirect, 0);
      chk("rstmid redirect_pc", o_redirect_pc, 0);
      chk("rstmid flush", o_flush, 0);
      chk("rstmid ready", o_br_ready, 0);
      chk("rstmid br_count", o_br_count, 0);
      chk("rstmid mispred_count", o_mispred_count, 0);
      i_rst = 1'b0;
      #1;
      chk("rstmid ready_after", o_br_ready, 1);
      tick();
      chk("rstmid no_redirect", o_redirect, 0);
      chk("rstmid no_flush", o_flush, 0);
      exp_br = '0;
      exp_mis = '0;

      for (int t = 0; t < 40; t++) begin
         kind = $urandom_range(0, 5);
         r.pc   = $urandom & 32'hFFFF_FFFC;
         r.rs1  = $urandom;
         r.rs2  = ($urandom_range(0, 3) == 0) ? r.rs1 : $urandom;
         r.imm  = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'h0000_0FFC);
         r.op   = alu_ctrl_e'(4'($urandom_range(0, 15)));
         r.jal  = (kind == 4);
         r.jalr = (kind == 5);
         r.pred = 1'($urandom);
         e = model(r);
         run_branch(r, e, 1'($urandom), $sformatf("rnd%0d", t));
      end

      for (int unsigned k = 1; k <= 8; k++) run_jal_w(32'h1000 + 32'(k) * 32'h10, 32'h40, k);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
